ps2_arrow_decoder: RTL and testbench

- Receives PS/2 keyboard frames and decodes extended arrow-key make/break sequences into held-level direction flags.
- Sits directly upstream of the game menu and game logic.
- Its `top`/`bottom`/`left`/`right` outputs drive the menu's navigation inputs, which handle their own repeat debouncing.
- Also exposes raw scan bytes and an error pulse for diagnostics.

---
 rtl/ps2_arrow_decoder.sv | 171 +++++++++++++++++
 tb/tb_ps2_arrow_decoder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_arrow_decoder.sv
// PS/2 keyboard receiver that turns extended arrow-key make/break sequences
// into held direction flags; raw bytes and framing errors are exposed for debug.
module ps2_arrow_decoder #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 13000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       top,
   output logic       bottom,
   output logic       left,
   output logic       right,
   output logic [7:0] scan_code,
   output logic       scan_valid,
   output logic       frame_err
);
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
   logic          flt_q, flt_d, fall_q, fall_d;
   logic [FW-1:0] flt_cnt_q, flt_cnt_d;
   state_t        state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d, code_q, code_d;
   logic          par_q, par_d, valid_q, valid_d, err_q, err_d;
   logic [TW-1:0] idle_q, idle_d;
   logic          ext_q, ext_d, brk_q, brk_d;
   logic [3:0]    flags_q, flags_d;  // {top, bottom, left, right}

   // Filter: flip only after FILTER_LEN consecutive disagreeing samples.
   always_comb begin
      flt_d     = flt_q;
      flt_cnt_d = '0;
      if (clk_s2_q != flt_q) begin
         if (flt_cnt_q == FW'(FILTER_LEN - 1)) flt_d = clk_s2_q;
         else                                  flt_cnt_d = flt_cnt_q + FW'(1);
      end
      fall_d = flt_q & ~flt_d;
   end

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      par_d     = par_q;
      code_d    = code_q;
      valid_d   = 1'b0;
      err_d     = 1'b0;
      idle_d    = '0;
      if (state_q != IDLE && !fall_q) begin
         if (idle_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d = IDLE;
            err_d   = 1'b1;
         end else begin
            idle_d = idle_q + TW'(1);
         end
      end
      if (fall_q) begin
         unique case (state_q)
            IDLE: begin
               if (!dat_s2_q) begin
                  state_d   = DATA;
                  bit_cnt_d = 3'd0;
               end else begin
                  err_d = 1'b1;
               end
            end
            DATA: begin
               shift_d   = {dat_s2_q, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = PARITY;
            end
            PARITY: begin
               par_d   = dat_s2_q;
               state_d = STOP;
            end
            STOP: begin
               if (dat_s2_q && ^{shift_q, par_q}) begin
                  code_d  = shift_q;
                  valid_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Prefix tracking: E0 marks extended, F0 marks break; any other byte consumes both.
   always_comb begin
      ext_d   = ext_q;
      brk_d   = brk_q;
      flags_d = flags_q;
      if (valid_q) begin
         if (code_q == 8'hE0) begin
            ext_d = 1'b1;
         end else if (code_q == 8'hF0) begin
            brk_d = 1'b1;
         end else begin
            if (ext_q) begin
               case (code_q)
                  8'h75:   flags_d[3] = ~brk_q;
                  8'h72:   flags_d[2] = ~brk_q;
                  8'h6B:   flags_d[1] = ~brk_q;
                  8'h74:   flags_d[0] = ~brk_q;
                  default: ;
               endcase
            end
            ext_d = 1'b0;
            brk_d = 1'b0;
         end
      end else if (err_q) begin
         ext_d = 1'b0;
         brk_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_s1_q  <= 1'b1;
         clk_s2_q  <= 1'b1;
         dat_s1_q  <= 1'b1;
         dat_s2_q  <= 1'b1;
         flt_q     <= 1'b1;
         flt_cnt_q <= '0;
         fall_q    <= 1'b0;
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         par_q     <= 1'b0;
         code_q    <= '0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
         idle_q    <= '0;
         ext_q     <= 1'b0;
         brk_q     <= 1'b0;
         flags_q   <= '0;
      end else begin
         clk_s1_q  <= ps2_clk;
         clk_s2_q  <= clk_s1_q;
         dat_s1_q  <= ps2_data;
         dat_s2_q  <= dat_s1_q;
         flt_q     <= flt_d;
         flt_cnt_q <= flt_cnt_d;
         fall_q    <= fall_d;
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
         code_q    <= code_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
         idle_q    <= idle_d;
         ext_q     <= ext_d;
         brk_q     <= brk_d;
         flags_q   <= flags_d;
      end
   end

   assign {top, bottom, left, right} = flags_q;
   assign scan_code  = code_q;
   assign scan_valid = valid_q;
   assign frame_err  = err_q;
endmodule

// File: tb/tb_ps2_arrow_decoder.sv
// Bench for ps2_arrow_decoder: vector table, hand-built corner sequences and
// random byte streams checked against a byte-level key-state model.
module tb_ps2_arrow_decoder;
   localparam int FLT  = 8;
   localparam int TMO  = 400;
   localparam int HALF = 30;

   logic       clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
   logic       top, bottom, left, right, scan_valid, frame_err;
   logic [7:0] scan_code;

   ps2_arrow_decoder #(.FILTER_LEN(FLT), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .top(top), .bottom(bottom), .left(left), .right(right),
      .scan_code(scan_code), .scan_valid(scan_valid), .frame_err(frame_err));

   always #5 clk = ~clk;

   int checks = 0, errors = 0, nv = 0, ne = 0;

   always @(negedge clk) begin
      if (scan_valid) nv++;
      if (frame_err) ne++;
      if (scan_valid || frame_err) begin
         checks++;
         if (scan_valid && frame_err) begin
            errors++;
            $display("FAIL pulse_overlap: scan_valid and frame_err both high at %0t", $time);
         end
      end
   end

   // Reference model: key state as a function of the accepted byte stream.
   logic [3:0] m_flags = '0;
   logic [7:0] m_code  = '0;
   bit         m_ext = 0, m_brk = 0;

   task automatic model_byte(input logic [7:0] b, input bit ok);
      int idx;
      if (!ok) begin
         m_ext = 0; m_brk = 0;
         return;
      end
      m_code = b;
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else begin
         idx = (b == 8'h75) ? 3 : (b == 8'h72) ? 2 : (b == 8'h6B) ? 1 : (b == 8'h74) ? 0 : -1;
         if (m_ext && idx >= 0) m_flags[idx] = !m_brk;
         m_ext = 0; m_brk = 0;
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit badp, input bit bads);
      return {~bads, badp ? ^b : ~^b, b, 1'b0};
   endfunction

   task automatic send_bits(input logic [10:0] f, input int first, input int last, input bit glitch);
      for (int i = first; i <= last; i++) begin
         ps2_data = f[i];
         tick(HALF);
         ps2_clk = 1'b0;
         tick(HALF);
         ps2_clk = 1'b1;
         if (glitch) begin
            tick(15);
            ps2_clk = 1'b0;
            tick(5);
            ps2_clk = 1'b1;
         end
      end
      ps2_data = 1'b1;
      tick(40);
   endtask

   task automatic send_checked(input string name, input logic [7:0] b, input bit badp, input bit bads,
                               input bit glitch);
      int v0, e0;
      v0 = nv; e0 = ne;
      send_bits(mk_frame(b, badp, bads), 0, 10, glitch);
      model_byte(b, !(badp || bads));
      chk({name, ".flags"}, {top, bottom, left, right}, m_flags);
      chk({name, ".code"}, scan_code, m_code);
      chk({name, ".valid"}, nv - v0, (badp || bads) ? 0 : 1);
      chk({name, ".err"}, ne - e0, (badp || bads) ? 1 : 0);
   endtask

   typedef struct {
      logic [7:0] b;
      bit         badp, bads;
      logic [3:0] exp_flags;
      logic [7:0] exp_code;
      int         exp_v, exp_e;
   } vec_t;
   vec_t tbl[$];

   initial begin
      logic [7:0] pool [7];
      int v0, e0;
      pool = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h00};

      tbl.push_back('{8'hE0, 0, 0, 4'b0000, 8'hE0, 1, 0});
      tbl.push_back('{8'h75, 0, 0, 4'b1000, 8'h75, 1, 0});
      tbl.push_back('{8'hE0, 0, 0, 4'b1000, 8'hE0, 1, 0});
      tbl.push_back('{8'hF0, 0, 0, 4'b1000, 8'hF0, 1, 0});
      tbl.push_back('{8'h75, 0, 0, 4'b0000, 8'h75, 1, 0});
      tbl.push_back('{8'h72, 0, 0, 4'b0000, 8'h72, 1, 0});
      tbl.push_back('{8'h6B, 1, 0, 4'b0000, 8'h72, 0, 1});
      tbl.push_back('{8'hE0, 0, 0, 4'b0000, 8'hE0, 1, 0});
      tbl.push_back('{8'h6B, 0, 0, 4'b0010, 8'h6B, 1, 0});
      tbl.push_back('{8'hE0, 0, 0, 4'b0010, 8'hE0, 1, 0});
      tbl.push_back('{8'h74, 0, 0, 4'b0011, 8'h74, 1, 0});
      tbl.push_back('{8'hE0, 0, 0, 4'b0011, 8'hE0, 1, 0});
      tbl.push_back('{8'h75, 0, 0, 4'b1011, 8'h75, 1, 0});
      tbl.push_back('{8'hE0, 0, 0, 4'b1011, 8'hE0, 1, 0});
      tbl.push_back('{8'h75, 0, 0, 4'b1011, 8'h75, 1, 0});
      tbl.push_back('{8'h75, 0, 0, 4'b1011, 8'h75, 1, 0});
      tbl.push_back('{8'hE0, 0, 0, 4'b1011, 8'hE0, 1, 0});
      tbl.push_back('{8'hF0, 0, 0, 4'b1011, 8'hF0, 1, 0});
      tbl.push_back('{8'h6B, 0, 0, 4'b1001, 8'h6B, 1, 0});
      tbl.push_back('{8'hE0, 0, 1, 4'b1001, 8'h6B, 0, 1});
      tbl.push_back('{8'hE0, 0, 0, 4'b1001, 8'hE0, 1, 0});
      tbl.push_back('{8'h72, 0, 0, 4'b1101, 8'h72, 1, 0});
      tbl.push_back('{8'hE0, 0, 0, 4'b1101, 8'hE0, 1, 0});
      tbl.push_back('{8'h6B, 1, 0, 4'b1101, 8'hE0, 0, 1});
      tbl.push_back('{8'h6B, 0, 0, 4'b1101, 8'h6B, 1, 0});

      tick(5);
      chk("reset.flags", {top, bottom, left, right}, 4'b0000);
      chk("reset.code", scan_code, 8'h00);
      chk("reset.pulses", {scan_valid, frame_err}, 2'b00);
      rst = 1'b0;
      tick(20);

      foreach (tbl[i]) begin
         v0 = nv; e0 = ne;
         send_bits(mk_frame(tbl[i].b, tbl[i].badp, tbl[i].bads), 0, 10, 0);
         model_byte(tbl[i].b, !(tbl[i].badp || tbl[i].bads));
         chk($sformatf("vec%0d.flags", i), {top, bottom, left, right}, tbl[i].exp_flags);
         chk($sformatf("vec%0d.code", i), scan_code, tbl[i].exp_code);
         chk($sformatf("vec%0d.valid", i), nv - v0, tbl[i].exp_v);
         chk($sformatf("vec%0d.err", i), ne - e0, tbl[i].exp_e);
      end

      // Timeout abort mid-frame, then a clean extended right arrow.
      v0 = nv; e0 = ne;
      send_bits(mk_frame(8'h00, 0, 0), 0, 4, 0);
      tick(TMO + 10);
      model_byte(8'h00, 0);
      chk("timeout.err", ne - e0, 1);
      chk("timeout.valid", nv - v0, 0);
      send_checked("tmo_e0", 8'hE0, 0, 0, 0);
      send_checked("tmo_74", 8'h74, 0, 0, 0);
      chk("timeout.right", right, 1'b1);

      // Short low glitches between bits must not create edges.
      send_checked("glitch_e0", 8'hE0, 0, 0, 1);
      send_checked("glitch_72", 8'h72, 0, 0, 1);

      // Reset in the middle of a frame with top held.
      send_checked("pre_rst_e0", 8'hE0, 0, 0, 0);
      send_checked("pre_rst_75", 8'h75, 0, 0, 0);
      chk("pre_rst.top", top, 1'b1);
      send_bits(mk_frame(8'h74, 0, 0), 0, 5, 0);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("midrst.outs", {top, bottom, left, right, scan_valid, frame_err}, 6'b0);
      chk("midrst.code", scan_code, 8'h00);
      m_flags = '0; m_code = '0; m_ext = 0; m_brk = 0;
      v0 = nv;
      send_bits(mk_frame(8'h74, 0, 0), 6, 10, 0);
      tick(TMO + 20);
      chk("midrst.no_valid", nv - v0, 0);
      model_byte(8'h00, 0);
      send_checked("post_rst_e0", 8'hE0, 0, 0, 0);
      send_checked("post_rst_75", 8'h75, 0, 0, 0);
      chk("post_rst.top", top, 1'b1);

      // Random byte stream with occasional corrupted frames.
      for (int k = 0; k < 40; k++) begin
         logic [7:0] b;
         bit bad;
         b = pool[$urandom_range(0, 6)];
         if (b == 8'h00) b = 8'($urandom);
         bad = ($urandom_range(0, 9) == 0);
         send_checked($sformatf("rnd%0d", k), b, bad, 0, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
